rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter CHANNELS, default 8: number of requesting channels, >=2.
REQ-002 Parameter WIDTH, default 32: data width per channel.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  CHANNELS  per-channel beat valid.
REQ-006 in_ready  output  CHANNELS  per-channel beat accept; at most one bit high.
REQ-007 in_data  input  CHANNELS*WIDTH  channel i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-008 in_last  input  CHANNELS  per-channel end-of-packet flag.
REQ-009 out_valid  output  1  registered output beat valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_last  output  1  registered end-of-packet flag.
REQ-013 out_grant  output  CHANNELS  one-hot source of the current output beat.
REQ-014 out_grant_id  output  $clog2(CHANNELS)  binary index of out_grant.

Function
REQ-015 Two states: IDLE (no owner), BUSY (one channel locked until its last beat transfers).
REQ-016 IDLE: in_ready all zero; if any in_valid, grant the first requester searching upward from pointer, wrapping CHANNELS-1 -> 0; move to BUSY with that owner next cycle.
REQ-017 IDLE with no in_valid: stay IDLE; pointer unchanged.
REQ-018 BUSY: in_ready[owner] = !out_valid || out_ready; all other in_ready bits zero.
REQ-019 Input transfer = in_valid[owner] && in_ready[owner]; on it load out_data, out_last, out_grant, out_grant_id from owner and set out_valid next cycle.
REQ-020 Output register holds its value while out_valid && !out_ready (no beat dropped or duplicated).
REQ-021 out_valid clears when out_ready is high and no input transfer occurs that cycle.
REQ-022 Simultaneous output accept and input transfer: register reloads, out_valid stays 1 (full throughput, one beat per cycle).
REQ-023 Transfer with in_last=1: state -> IDLE, pointer <= (owner+1) mod CHANNELS.
REQ-024 Latency: in_valid first seen in IDLE at cycle N -> earliest out_valid at N+2; packet-to-packet gap is one IDLE cycle.
REQ-025 in_valid withdrawn by owner mid-packet: remain BUSY, no transfer, lock held.
REQ-026 Non-owner requests never affect out_* or the owner during BUSY.
REQ-027 out_grant always one-hot while out_valid; out_grant_id consistent with it.

Reset
REQ-028 Asserting reset (low) immediately forces state IDLE, pointer 0, out_valid 0, out_last 0, out_data 0, out_grant 0, out_grant_id 0, in_ready 0, including mid-packet.
REQ-029 Reset deassertion mid-traffic: first arbitration on the next clock edge, channel 0 has highest priority.

Structure
REQ-030 Shared package rr_arb_pkg holds the state encoding (IDLE, BUSY) and the index-width constant function.
REQ-031 Sub-module rr_arb_pick: combinational round-robin picker (requests, pointer -> one-hot grant, index); no other sub-modules.

Verification (CHANNELS=4, WIDTH=8)
REQ-032 Reset: drive reset low during a BUSY packet -> all outputs 0 same cycle; after release, in_valid=4'b1111 grants channel 0.
REQ-033 Fairness: all four channels continuously valid, single-beat packets (in_last=1), out_ready=1 -> out_grant_id sequence 0,1,2,3,0,1.
REQ-034 Packet lock: ch2 sends 3 beats 0xA0,0xA1,0xA2 (last on third) while ch0/ch1 valid -> three consecutive ch2 beats, then grant ch3 if valid else wrap to ch0.
REQ-035 Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data frozen, in_ready[owner]=0, no beat lost; release -> remaining beats in order.
REQ-036 Wrap: pointer at 3, only ch1 valid -> ch1 granted; pointer becomes 2 after its last beat.
REQ-037 Throughput: out_ready=1, ch1 16-beat packet -> out_valid continuous for 16 cycles starting N+2.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared arbiter state encoding and index-width helper.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker.
//   req   - per-channel request vector
//   ptr   - highest-priority channel; search runs upward and wraps
//   grant - one-hot winner (all zero when no request)
//   idx   - binary index of the winner
module rr_arb_pick
    import rr_arb_pkg::*;
#(
    parameter int CHANNELS = 8
) (
    input  logic [CHANNELS-1:0]          req,
    input  logic [idx_w(CHANNELS)-1:0]   ptr,
    output logic [CHANNELS-1:0]          grant,
    output logic [idx_w(CHANNELS)-1:0]   idx
);

    localparam int IW = idx_w(CHANNELS);

    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            j = IW'((int'(ptr) + i) % CHANNELS);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: packet-locked round-robin arbiter with a registered output beat.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data/in_last - per-channel packet streams
//   out_valid/out_ready/out_data/out_last - registered output stream
//   out_grant/out_grant_id - one-hot and binary source of the current beat
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic [CHANNELS-1:0]           in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_last,
    output logic [CHANNELS-1:0]           out_grant,
    output logic [idx_w(CHANNELS)-1:0]    out_grant_id
);

    localparam int IW = idx_w(CHANNELS);

    state_t              state, state_nxt;
    logic [IW-1:0]       owner, owner_nxt;
    logic [IW-1:0]       ptr, ptr_nxt;
    logic [CHANNELS-1:0] pick_grant;
    logic [IW-1:0]       pick_idx;
    logic                owner_rdy;
    logic                xfer;

    rr_arb_pick #(.CHANNELS(CHANNELS)) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // The owner may push whenever the output register is empty or draining.
    assign owner_rdy = (state == BUSY) && (!out_valid || out_ready);
    assign in_ready  = owner_rdy ? (CHANNELS'(1) << owner) : '0;
    assign xfer      = owner_rdy && in_valid[owner];

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        if (state == IDLE) begin
            if (|pick_grant) begin
                state_nxt = BUSY;
                owner_nxt = pick_idx;
            end
        end else if (xfer && in_last[owner]) begin
            state_nxt = IDLE;
            ptr_nxt   = (owner == IW'(CHANNELS - 1)) ? '0 : owner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_grant    <= '0;
            out_grant_id <= '0;
        end else if (xfer) begin
            out_valid    <= 1'b1;
            out_data     <= in_data[owner*WIDTH +: WIDTH];
            out_last     <= in_last[owner];
            out_grant    <= CHANNELS'(1) << owner;
            out_grant_id <= owner;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed bench with a per-cycle behavioural model of the arbiter.
module tb_rr_arb_mux;

    localparam int C = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [C-1:0]   in_valid = '0;
    logic [C-1:0]   in_ready;
    logic [C*W-1:0] in_data = '0;
    logic [C-1:0]   in_last = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [C-1:0]   out_grant;
    logic [1:0]     out_grant_id;

    always #5 clk = ~clk;

    rr_arb_mux #(.CHANNELS(C), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_grant    (out_grant),
        .out_grant_id (out_grant_id)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet sources: channel c sends src_len beats starting at src_base.
    int         src_len[C];
    int         src_cnt[C];
    logic [W-1:0] src_base[C];
    bit         src_en[C];
    bit         src_rep[C];
    bit         src_pause[C];
    logic [C-1:0] fire_q = '0;
    logic       nxt_ready = 1'b1;

    logic [1:0]   obs_id[$];
    logic [W-1:0] obs_d[$];

    // Model: owner (-1 = none), pointer, output register contents.
    int           m_own = -1;
    int           m_ptr = 0;
    int           m_gid = 0;
    bit           m_ov = 0;
    bit           m_ol = 0;
    bit           mx = 0;
    logic [W-1:0] m_od = '0;

    always @(negedge clk) begin
        if (!reset) begin
            m_own = -1;
            m_ptr = 0;
            m_ov  = 0;
            m_ol  = 0;
            m_od  = '0;
            m_gid = 0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("in_ready", 32'(in_ready),
                (m_own >= 0 && (!m_ov || out_ready)) ? (32'd1 << m_own) : 32'd0);
            if (m_ov) begin
                chk("out_data", 32'(out_data), 32'(m_od));
                chk("out_last", 32'(out_last), 32'(m_ol));
                chk("out_grant_id", 32'(out_grant_id), 32'(m_gid));
                chk("out_grant", 32'(out_grant), 32'd1 << m_gid);
            end
            if (out_valid && out_ready) begin
                obs_id.push_back(out_grant_id);
                obs_d.push_back(out_data);
            end
            mx = m_own >= 0 && (!m_ov || out_ready) && in_valid[2'(m_own)];
            if (mx) begin
                m_ov  = 1;
                m_od  = W'(in_data >> (m_own * W));
                m_ol  = in_last[2'(m_own)];
                m_gid = m_own;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (m_own < 0) begin
                for (int k = 0; k < C; k++)
                    if (m_own < 0 && in_valid[2'((m_ptr + k) % C)]) m_own = (m_ptr + k) % C;
            end else if (mx && m_ol) begin
                m_ptr = (m_own + 1) % C;
                m_own = -1;
            end
        end
    end

    task automatic drive();
        logic [C-1:0] v;
        logic [C-1:0] l;
        logic [W-1:0] d[C];
        for (int c = 0; c < C; c++) begin
            v[2'(c)] = src_en[c] && !src_pause[c];
            l[2'(c)] = (src_cnt[c] == src_len[c] - 1);
            d[c]     = src_base[c] + W'(src_cnt[c]);
        end
        in_valid  = v;
        in_last   = l;
        in_data   = {d[3], d[2], d[1], d[0]};
        out_ready = nxt_ready;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int c = 0; c < C; c++) begin
            if (fire_q[2'(c)]) begin
                src_cnt[c]++;
                if (src_cnt[c] == src_len[c]) begin
                    src_cnt[c] = 0;
                    if (!src_rep[c]) src_en[c] = 0;
                end
            end
        end
        drive();
        @(negedge clk);
        fire_q = in_valid & in_ready;
        #1;
    endtask

    task automatic clr_src();
        for (int c = 0; c < C; c++) begin
            src_en[c]    = 0;
            src_rep[c]   = 0;
            src_pause[c] = 0;
            src_len[c]   = 0;
            src_cnt[c]   = 0;
            src_base[c]  = '0;
        end
        fire_q = '0;
    endtask

    task automatic setsrc(input int c, input logic [W-1:0] b, input int len, input bit rep);
        src_base[c]  = b;
        src_len[c]   = len;
        src_cnt[c]   = 0;
        src_rep[c]   = rep;
        src_pause[c] = 0;
        src_en[c]    = 1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clr_src();
        nxt_ready = 1'b1;
        drive();
        cyc();
        cyc();
        reset = 1'b1;
        obs_id.delete();
        obs_d.delete();
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_id.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk("wait_obs", 32'(obs_id.size() >= n), 32'd1);
    endtask

    task automatic chk_obs(input string name, input int i, input logic [1:0] id, input logic [W-1:0] d);
        chk({name, "_id"}, 32'(obs_id[i]), 32'(id));
        chk({name, "_data"}, 32'(obs_d[i]), 32'(d));
    endtask

    initial begin
        clr_src();
        drive();
        cyc();
        cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;

        // Fairness: single-beat packets from every channel.
        for (int c = 0; c < C; c++) setsrc(c, W'(c * 16), 1, 1);
        wait_obs(6, 40);
        chk_obs("fair0", 0, 2'd0, 8'h00);
        chk_obs("fair1", 1, 2'd1, 8'h10);
        chk_obs("fair2", 2, 2'd2, 8'h20);
        chk_obs("fair3", 3, 2'd3, 8'h30);
        chk_obs("fair4", 4, 2'd0, 8'h00);
        chk_obs("fair5", 5, 2'd1, 8'h10);

        // Reset in the middle of a ch3 packet, then arbitration from channel 0.
        do_reset();
        setsrc(3, 8'hC0, 4, 0);
        wait_obs(1, 20);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_grant", 32'(out_grant), 32'd0);
        chk("mid_rst_out_grant_id", 32'(out_grant_id), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        clr_src();
        drive();
        cyc();
        obs_id.delete();
        obs_d.delete();
        for (int c = 0; c < C; c++) setsrc(c, W'(c * 16 + 1), 1, 0);
        reset = 1'b1;
        wait_obs(4, 30);
        chk_obs("post_rst0", 0, 2'd0, 8'h01);
        chk_obs("post_rst3", 3, 2'd3, 8'h31);

        // Packet lock with backpressure: pointer moved to 2 by a ch1 beat first.
        do_reset();
        setsrc(1, 8'h55, 1, 0);
        wait_obs(1, 20);
        cyc();
        cyc();
        obs_id.delete();
        obs_d.delete();
        setsrc(0, 8'h00, 1, 0);
        setsrc(1, 8'h10, 1, 0);
        setsrc(2, 8'hA0, 3, 0);
        wait_obs(1, 20);
        nxt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_data", 32'(out_data), 32'hA1);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        nxt_ready = 1'b1;
        wait_obs(5, 30);
        chk_obs("lock0", 0, 2'd2, 8'hA0);
        chk_obs("lock1", 1, 2'd2, 8'hA1);
        chk_obs("lock2", 2, 2'd2, 8'hA2);
        chk_obs("lock3", 3, 2'd0, 8'h00);
        chk_obs("lock4", 4, 2'd1, 8'h10);

        // Wrap: pointer at 3, only ch1 valid; pointer then lands on 2.
        do_reset();
        setsrc(2, 8'h22, 1, 0);
        wait_obs(1, 20);
        cyc();
        cyc();
        obs_id.delete();
        obs_d.delete();
        setsrc(1, 8'h11, 1, 0);
        wait_obs(1, 20);
        cyc();
        cyc();
        setsrc(0, 8'h00, 1, 0);
        setsrc(2, 8'h20, 1, 0);
        setsrc(3, 8'h30, 1, 0);
        wait_obs(4, 30);
        chk_obs("wrap0", 0, 2'd1, 8'h11);
        chk_obs("wrap1", 1, 2'd2, 8'h20);
        chk_obs("wrap2", 2, 2'd3, 8'h30);
        chk_obs("wrap3", 3, 2'd0, 8'h00);

        // Throughput and latency: 16-beat ch1 packet, valid continuous from N+2.
        do_reset();
        setsrc(1, 8'h40, 16, 0);
        cyc();
        chk("lat_n", 32'(out_valid), 32'd0);
        cyc();
        chk("lat_n1", 32'(out_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("tp_valid", 32'(out_valid), 32'd1);
            chk("tp_data", 32'(out_data), 32'h40 + 32'(i));
        end
        cyc();
        chk("tp_end", 32'(out_valid), 32'd0);

        // Owner withdraws valid mid-packet while ch1 waits.
        do_reset();
        setsrc(0, 8'h70, 3, 0);
        setsrc(1, 8'h80, 1, 0);
        wait_obs(1, 20);
        src_pause[0] = 1;
        for (int i = 0; i < 4; i++) cyc();
        chk("hold_valid", 32'(out_valid), 32'd0);
        src_pause[0] = 0;
        wait_obs(4, 30);
        chk_obs("hold0", 1, 2'd0, 8'h71);
        chk_obs("hold1", 2, 2'd0, 8'h72);
        chk_obs("hold2", 3, 2'd1, 8'h80);

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
